pwr_wr_arbiter: RTL and testbench
=================================

PWR_WR_ARBITER -- requirements
Module: pwr_wr_arbiter

Interface
REQ-001 Parameter STARVE_LIMIT, default 4: maximum consecutive port-0 grants while port 1 is waiting.
REQ-002 Parameter TIMEOUT_CYCLES, default 256: abort threshold in cycles; used only when the timeout macro is defined.
REQ-003 Clock and reset: one clock, seq_port.clk; reset seq_port.rst is synchronous and active-high.
REQ-004 seq_port.clk  input  1  clock; all logic on the rising edge.
REQ-005 seq_port.rst  input  1  synchronous active-high reset.
REQ-006 req_i  input  2  per-port write request, level; bit0 = maestro, bit1 = fsm.
REQ-007 addr_i  input  2x32  per-port target address; must be stable while req is high.
REQ-008 data_i  input  2x32  per-port write data; must be stable while req is high.
REQ-009 ack_o  output  2  per-port one-cycle completion pulse.
REQ-010 err_o  output  1  one-cycle pulse coincident with ack_o when the write failed.
REQ-011 axi_master  AXI_LITE.Master  -  AW, W and B channels driven; AR and R tied inactive (ar_valid=0, r_ready=0).

Function
REQ-012 FSM states: IDLE, SEND, RESP, DONE.
REQ-013 IDLE: if any req_i bit is set, grant one port, latch its addr/data into internal registers, and go to SEND the next cycle.
REQ-014 Priority: port 0 wins, except when port 1 is requesting and the consecutive-port-0 counter equals STARVE_LIMIT; then port 1 wins.
REQ-015 Consecutive counter: increments on a port-0 grant while req_i[1]=1; clears on any port-1 grant or when req_i[1]=0.
REQ-016 SEND: aw_valid and w_valid are asserted together with the latched address and data; w_strb=4'hF; aw_prot=0.
REQ-017 Each valid deasserts independently on the edge after its own ready is seen high; the FSM moves to RESP once both handshakes have completed, in either order or in the same cycle.
REQ-018 RESP: b_ready=1; on b_valid, capture b_resp and go to DONE.
REQ-019 DONE: ack_o[granted]=1 for exactly one cycle; err_o=1 if the captured b_resp is nonzero; return to IDLE.
REQ-020 A requester drops req on the cycle after ack; the arbiter never re-grants the same port in the cycle that ack_o is high.
REQ-021 Minimum latency, req rising edge to ack_o, is 4 cycles with an always-ready slave (IDLE, SEND, RESP, DONE).
REQ-022 Only one write is outstanding at a time; a req arriving on a non-granted port waits with no loss.
REQ-023 A request dropped before grant is ignored; a request dropped after grant still completes and still acks.
REQ-024 Addr/data changes after grant have no effect on the in-flight write.

Reset
REQ-025 With seq_port.rst=1 at an edge: state=IDLE; aw_valid, w_valid, b_ready, ack_o and err_o = 0; consecutive counter = 0; timeout counter = 0.
REQ-026 Reset mid-transaction abandons the write with no ack; valids are low on the first cycle after the reset edge.

Configuration
REQ-027 Macro PWR_WR_ARB_TIMEOUT_EN defined: a counter runs in SEND and RESP; when it reaches TIMEOUT_CYCLES, all valids drop, the FSM goes to DONE, and err_o=1 with ack_o.
REQ-028 Macro PWR_WR_ARB_TIMEOUT_EN undefined: no timeout counter exists, the arbiter waits indefinitely, and err_o reflects only b_resp.

Verification
REQ-029 Single port-0 write, addr 0x100, data 0x2, slave always ready -> AW/W carry 0x100/0x2; ack_o=01 at cycle 4; err_o=0.
REQ-030 Both ports request continuously, STARVE_LIMIT=4 -> grant order 0,0,0,0,1,0,0,0,0,1.
REQ-031 aw_ready delayed 3 cycles, w_ready immediate -> w_valid drops after 1 cycle, aw_valid after 4; exactly one B accepted; single ack.
REQ-032 Slave returns b_resp=2'b10 for a port-1 write -> ack_o=10 and err_o=1 in the same cycle.
REQ-033 PWR_WR_ARB_TIMEOUT_EN defined, TIMEOUT_CYCLES=8, b_valid never asserted -> ack with err_o=1 about 9 cycles after SEND entry; the next request proceeds normally.
REQ-034 seq_port.rst asserted in RESP -> no ack; state IDLE; a pending req_i is regranted after reset deasserts.

Source files
------------

// File: rtl/pwr_wr_arbiter_if.sv
`default_nettype none
// ============================================================================
// Module      : pwr_seq_if / axi_lite_if
// Description : Interfaces used by pwr_wr_arbiter.
//               pwr_seq_if  - clock and synchronous active-high reset bundle.
//               axi_lite_if - 32-bit AXI4-Lite bus (AW, W, B, AR, R channels).
// Ports       : pwr_seq_if.slave   : clk, rst inputs
//               axi_lite_if.master : drives AW/W/B-ready/AR/R-ready
//               axi_lite_if.slave  : drives ready/response side
// Revision    : 1.0 - initial release
// ============================================================================

interface pwr_seq_if;
  logic clk;
  logic rst;

  modport master (output clk, output rst);
  modport slave  (input  clk, input  rst);
endinterface

interface axi_lite_if;
  // Write address channel
  logic        aw_valid;
  logic        aw_ready;
  logic [31:0] aw_addr;
  logic [2:0]  aw_prot;
  // Write data channel
  logic        w_valid;
  logic        w_ready;
  logic [31:0] w_data;
  logic [3:0]  w_strb;
  // Write response channel
  logic        b_valid;
  logic        b_ready;
  logic [1:0]  b_resp;
  // Read address channel
  logic        ar_valid;
  logic        ar_ready;
  logic [31:0] ar_addr;
  logic [2:0]  ar_prot;
  // Read data channel
  logic        r_valid;
  logic        r_ready;
  logic [31:0] r_data;
  logic [1:0]  r_resp;

  modport master (
    output aw_valid, aw_addr, aw_prot,
    output w_valid, w_data, w_strb,
    output b_ready,
    output ar_valid, ar_addr, ar_prot,
    output r_ready,
    input  aw_ready, w_ready,
    input  b_valid, b_resp,
    input  ar_ready,
    input  r_valid, r_data, r_resp
  );

  modport slave (
    input  aw_valid, aw_addr, aw_prot,
    input  w_valid, w_data, w_strb,
    input  b_ready,
    input  ar_valid, ar_addr, ar_prot,
    input  r_ready,
    output aw_ready, w_ready,
    output b_valid, b_resp,
    output ar_ready,
    output r_valid, r_data, r_resp
  );
endinterface

`default_nettype wire

// File: rtl/pwr_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : pwr_wr_arbiter
// Description : Two-port write arbiter onto a single AXI4-Lite master. Port 0
//               (maestro) has priority; port 1 (fsm) is guaranteed a grant after
//               STARVE_LIMIT consecutive port-0 grants while it waits. One write
//               is outstanding at a time; completion is a one-cycle ack pulse
//               with an error flag taken from the B response.
// Ports       : seq_port   - clock / synchronous active-high reset
//               req_i      - per-port level write request (bit0 maestro, bit1 fsm)
//               addr_i     - per-port target address
//               data_i     - per-port write data
//               ack_o      - per-port one-cycle completion pulse
//               err_o      - error pulse coincident with ack_o
//               axi_master - AXI4-Lite master (AR/R tied inactive)
// Options     : `define PWR_WR_ARB_TIMEOUT_EN to abort writes that spend
//               TIMEOUT_CYCLES cycles in SEND/RESP (completes with err_o=1).
// Revision    : 1.0 - initial release
// ============================================================================

module pwr_wr_arbiter #(
  parameter int STARVE_LIMIT   = 4,
  parameter int TIMEOUT_CYCLES = 256
) (
  pwr_seq_if.slave          seq_port,
  input  logic [1:0]        req_i,
  input  logic [1:0][31:0]  addr_i,
  input  logic [1:0][31:0]  data_i,
  output logic [1:0]        ack_o,
  output logic              err_o,
  axi_lite_if.master        axi_master
);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_SEND = 2'd1,
    S_RESP = 2'd2,
    S_DONE = 2'd3
  } state_t;

  localparam int              c_starve_w   = $clog2(STARVE_LIMIT + 1);
  localparam logic [c_starve_w-1:0] c_starve_max = STARVE_LIMIT[c_starve_w-1:0];

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic                    r_gnt;
  logic [31:0]             r_addr;
  logic [31:0]             r_data;
  logic                    r_aw_valid;
  logic                    r_w_valid;
  logic [1:0]              r_bresp;
  logic [c_starve_w-1:0]   r_starve_cnt;

  logic                    w_any_req;
  logic                    w_gnt_sel;
  logic                    w_aw_done;
  logic                    w_w_done;
  logic                    w_abort;
  logic                    w_timeout_err;

  assign w_any_req = |req_i;
  // Port 1 wins when it is the only requester or when port 0 has used up its
  // allowance of back-to-back grants while port 1 was waiting.
  assign w_gnt_sel = req_i[1] & (~req_i[0] | (r_starve_cnt == c_starve_max));

  // A channel is finished once its valid has dropped or it is handshaking now.
  assign w_aw_done = ~r_aw_valid | axi_master.aw_ready;
  assign w_w_done  = ~r_w_valid  | axi_master.w_ready;

`ifdef PWR_WR_ARB_TIMEOUT_EN
  localparam int                   c_to_w   = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [c_to_w-1:0]    c_to_max = TIMEOUT_CYCLES[c_to_w-1:0];

  logic [c_to_w-1:0] r_to_cnt;
  logic              r_to_flag;
  logic              w_busy;

  assign w_busy        = (r_state == S_SEND) | (r_state == S_RESP);
  assign w_abort       = w_busy & (r_to_cnt == c_to_max);
  assign w_timeout_err = r_to_flag;

  always_ff @(posedge seq_port.clk) begin
    if (seq_port.rst) begin
      r_to_cnt  <= '0;
      r_to_flag <= 1'b0;
    end else begin
      if (!w_busy) begin
        r_to_cnt <= '0;
      end else if (!w_abort) begin
        r_to_cnt <= r_to_cnt + 1'b1;
      end
      if (r_state == S_IDLE) begin
        r_to_flag <= 1'b0;
      end else if (w_abort) begin
        r_to_flag <= 1'b1;
      end
    end
  end
`else
  localparam int unused_timeout_cycles = TIMEOUT_CYCLES;
  assign w_abort       = 1'b0;
  assign w_timeout_err = 1'b0;
`endif

  // Next-state logic
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: if (w_any_req) w_state_nxt = S_SEND;
      S_SEND: begin
        if (w_abort) begin
          w_state_nxt = S_DONE;
        end else if (w_aw_done && w_w_done) begin
          w_state_nxt = S_RESP;
        end
      end
      S_RESP: begin
        if (w_abort || axi_master.b_valid) w_state_nxt = S_DONE;
      end
      S_DONE:  w_state_nxt = S_IDLE;
      default: w_state_nxt = S_IDLE;
    endcase
  end

  // Completion outputs, all decoded from registered state
  always_comb begin
    ack_o = 2'b00;
    err_o = 1'b0;
    if (r_state == S_DONE) begin
      ack_o[r_gnt] = 1'b1;
      err_o        = (r_bresp != 2'b00) | w_timeout_err;
    end
  end

  always_ff @(posedge seq_port.clk) begin
    if (seq_port.rst) begin
      r_state      <= S_IDLE;
      r_gnt        <= 1'b0;
      r_addr       <= '0;
      r_data       <= '0;
      r_aw_valid   <= 1'b0;
      r_w_valid    <= 1'b0;
      r_bresp      <= 2'b00;
      r_starve_cnt <= '0;
    end else begin
      r_state <= w_state_nxt;
      case (r_state)
        S_IDLE: begin
          if (w_any_req) begin
            // Latch the winner's request so later input changes cannot
            // disturb the write in flight.
            r_gnt      <= w_gnt_sel;
            r_addr     <= addr_i[w_gnt_sel];
            r_data     <= data_i[w_gnt_sel];
            r_aw_valid <= 1'b1;
            r_w_valid  <= 1'b1;
            r_bresp    <= 2'b00;
          end
        end
        S_SEND: begin
          if (w_abort) begin
            r_aw_valid <= 1'b0;
            r_w_valid  <= 1'b0;
          end else begin
            if (r_aw_valid && axi_master.aw_ready) r_aw_valid <= 1'b0;
            if (r_w_valid  && axi_master.w_ready)  r_w_valid  <= 1'b0;
          end
        end
        S_RESP: begin
          if (axi_master.b_valid && !w_abort) r_bresp <= axi_master.b_resp;
        end
        default: ;
      endcase

      // Counts port-0 wins only while port 1 is actually waiting.
      if (!req_i[1]) begin
        r_starve_cnt <= '0;
      end else if ((r_state == S_IDLE) && w_any_req) begin
        if (w_gnt_sel) begin
          r_starve_cnt <= '0;
        end else if (r_starve_cnt != c_starve_max) begin
          r_starve_cnt <= r_starve_cnt + 1'b1;
        end
      end
    end
  end

  assign axi_master.aw_valid = r_aw_valid;
  assign axi_master.aw_addr  = r_addr;
  assign axi_master.aw_prot  = 3'b000;
  assign axi_master.w_valid  = r_w_valid;
  assign axi_master.w_data   = r_data;
  assign axi_master.w_strb   = 4'hF;
  assign axi_master.b_ready  = (r_state == S_RESP);
  assign axi_master.ar_valid = 1'b0;
  assign axi_master.ar_addr  = '0;
  assign axi_master.ar_prot  = 3'b000;
  assign axi_master.r_ready  = 1'b0;

  // Read channels are never used.
  logic w_unused_read;
  assign w_unused_read = &{1'b0, axi_master.ar_ready, axi_master.r_valid,
                           axi_master.r_data, axi_master.r_resp};

endmodule

`default_nettype wire

// File: tb/tb_pwr_wr_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_pwr_wr_arbiter
// Description : Scoreboard bench for pwr_wr_arbiter. Stimulus pushes expected
//               writes into a queue; a monitor pops and compares on every ack.
//               A reactive AXI-Lite slave model with programmable AW/W delays
//               and B response answers the DUT.
// Revision    : 1.0 - initial release
// ============================================================================

module tb_pwr_wr_arbiter;

  localparam int STARVE = 4;
  localparam int TMO    = 8;

  pwr_seq_if  seq ();
  axi_lite_if axi ();

  logic [1:0]       req;
  logic [1:0][31:0] addr;
  logic [1:0][31:0] data;
  logic [1:0]       ack;
  logic             err;

  pwr_wr_arbiter #(
    .STARVE_LIMIT   (STARVE),
    .TIMEOUT_CYCLES (TMO)
  ) dut (
    .seq_port   (seq),
    .req_i      (req),
    .addr_i     (addr),
    .data_i     (data),
    .ack_o      (ack),
    .err_o      (err),
    .axi_master (axi)
  );

  initial seq.clk = 1'b0;
  always #5 seq.clk = ~seq.clk;

  int cyc = 0;
  always @(posedge seq.clk) cyc <= cyc + 1;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    int          port;
    logic [31:0] addr;
    logic [31:0] data;
    logic        err;
  } exp_t;

  exp_t sb[$];

  task automatic expect_wr(input int p, input logic [31:0] a, input logic [31:0] d, input logic e);
    exp_t x;
    x.port = p; x.addr = a; x.data = d; x.err = e;
    sb.push_back(x);
  endtask

  // ---------------- slave model ----------------
  int          aw_dly = 0;
  int          w_dly  = 0;
  logic        b_en   = 1'b1;
  logic [1:0]  b_resp_val = 2'b00;
  logic        got_aw, got_w, b_pend;
  int          aw_wait, w_wait, aw_len, w_len, b_count;
  logic [31:0] cap_addr, cap_data;
  logic [3:0]  cap_strb;
  logic [2:0]  cap_prot;

  initial begin
    axi.aw_ready = 0; axi.w_ready = 0; axi.b_valid = 0; axi.b_resp = 0;
    axi.ar_ready = 0; axi.r_valid = 0; axi.r_data = 0; axi.r_resp = 0;
    got_aw = 0; got_w = 0; b_pend = 0; aw_wait = 0; w_wait = 0;
    aw_len = 0; w_len = 0; b_count = 0;
    cap_addr = 0; cap_data = 0; cap_strb = 0; cap_prot = 0;
    forever begin
      @(negedge seq.clk);
      if (seq.rst) begin
        axi.aw_ready = 0; axi.w_ready = 0; axi.b_valid = 0; axi.b_resp = 0;
        got_aw = 0; got_w = 0; b_pend = 0; aw_wait = 0; w_wait = 0;
      end else begin
        if (|ack) begin
          got_aw = 0; got_w = 0;
        end
        if (axi.aw_valid) begin
          axi.aw_ready = (aw_wait >= aw_dly);
          if (axi.aw_ready && !got_aw) begin
            got_aw = 1; cap_addr = axi.aw_addr; cap_prot = axi.aw_prot; aw_len = aw_wait + 1;
          end
          aw_wait++;
        end else begin
          axi.aw_ready = 0; aw_wait = 0;
        end
        if (axi.w_valid) begin
          axi.w_ready = (w_wait >= w_dly);
          if (axi.w_ready && !got_w) begin
            got_w = 1; cap_data = axi.w_data; cap_strb = axi.w_strb; w_len = w_wait + 1;
          end
          w_wait++;
        end else begin
          axi.w_ready = 0; w_wait = 0;
        end
        if (b_pend) begin
          axi.b_valid = 0; axi.b_resp = 0; b_pend = 0;
        end else if (got_aw && got_w && b_en && axi.b_ready) begin
          axi.b_valid = 1; axi.b_resp = b_resp_val; b_pend = 1; b_count++;
          got_aw = 0; got_w = 0;
        end
      end
    end
  end

  // ---------------- monitor ----------------
  initial begin
    exp_t        e;
    logic [1:0]  exp_ack;
    forever begin
      @(negedge seq.clk);
      if (ack != 2'b00) begin
        if (sb.size() == 0) begin
          n_tests++; n_fail++;
          $display("FAIL unexpected_ack: got ack=%b expected none", ack);
        end else begin
          e = sb.pop_front();
          exp_ack = 2'b01 << e.port;
          check("ack_port", 64'(ack), 64'(exp_ack));
          check("err",      64'(err), 64'(e.err));
          check("aw_addr",  64'(cap_addr), 64'(e.addr));
          check("w_data",   64'(cap_data), 64'(e.data));
          check("w_strb",   64'(cap_strb), 64'hF);
          check("aw_prot",  64'(cap_prot), 64'h0);
        end
      end else if (err) begin
        n_tests++; n_fail++;
        $display("FAIL err_without_ack: got err=1 expected 0");
      end
    end
  end

  // ---------------- stimulus ----------------
  task automatic tick(input int n);
    repeat (n) @(negedge seq.clk);
  endtask

  task automatic wait_ack(input logic [1:0] mask, output int acyc);
    acyc = -1;
    for (int k = 0; k < 200; k++) begin
      @(negedge seq.clk);
      if ((ack & mask) != 2'b00) begin
        acyc = cyc;
        break;
      end
    end
    if (acyc < 0) begin
      n_tests++; n_fail++;
      $display("FAIL ack_timeout: got no ack expected ack on mask %b", mask);
    end
  endtask

  initial begin
    int rcyc, acyc, b0;
    req = 0; addr = '0; data = '0;
    seq.rst = 1'b1;
    tick(3);
    check("rst_aw_valid", 64'(axi.aw_valid), 0);
    check("rst_w_valid",  64'(axi.w_valid),  0);
    check("rst_b_ready",  64'(axi.b_ready),  0);
    check("rst_ack",      64'(ack),          0);
    check("rst_err",      64'(err),          0);
    check("ar_valid",     64'(axi.ar_valid), 0);
    check("r_ready",      64'(axi.r_ready),  0);
    seq.rst = 1'b0;
    tick(2);

    // Single port-0 write, always-ready slave: ack in the 4th cycle
    expect_wr(0, 32'h100, 32'h2, 1'b0);
    addr[0] = 32'h100; data[0] = 32'h2; req[0] = 1'b1; rcyc = cyc;
    wait_ack(2'b01, acyc);
    req[0] = 1'b0;
    check("latency_basic", 64'(acyc - rcyc), 3);
    tick(2);

    // Port-1 write with SLVERR; inputs change after grant
    b_resp_val = 2'b10;
    expect_wr(1, 32'h300, 32'h55, 1'b1);
    addr[1] = 32'h300; data[1] = 32'h55; req[1] = 1'b1;
    tick(1);
    addr[1] = 32'hBAD0; data[1] = 32'hBAD1;
    wait_ack(2'b10, acyc);
    req[1] = 1'b0;
    b_resp_val = 2'b00;
    tick(2);

    // AW ready delayed 3 cycles, W immediate
    aw_dly = 3; b0 = b_count;
    expect_wr(0, 32'h104, 32'h7, 1'b0);
    addr[0] = 32'h104; data[0] = 32'h7; req[0] = 1'b1; rcyc = cyc;
    wait_ack(2'b01, acyc);
    req[0] = 1'b0;
    check("aw_valid_len", 64'(aw_len), 4);
    check("w_valid_len",  64'(w_len),  1);
    check("b_accepted",   64'(b_count - b0), 1);
    check("latency_awdly", 64'(acyc - rcyc), 6);
    aw_dly = 0;
    tick(4);

    // Both ports requesting continuously: 0,0,0,0,1,0,0,0,0,1
    addr[0] = 32'h200; data[0] = 32'hA0;
    addr[1] = 32'h300; data[1] = 32'hB0;
    for (int g = 0; g < 10; g++) begin
      if (g == 4 || g == 9) expect_wr(1, 32'h300, 32'hB0, 1'b0);
      else                  expect_wr(0, 32'h200, 32'hA0, 1'b0);
    end
    req = 2'b11;
    for (int g = 0; g < 10; g++) wait_ack(2'b11, acyc);
    req = 2'b00;
    tick(3);

    // Reset while waiting in RESP abandons the write; pending req regranted
    b_en = 1'b0;
    addr[0] = 32'h400; data[0] = 32'h44; req[0] = 1'b1;
    acyc = -1;
    for (int k = 0; k < 20; k++) begin
      @(negedge seq.clk);
      if (axi.b_ready) begin acyc = cyc; break; end
    end
    check("reached_resp", 64'(acyc >= 0), 1);
    seq.rst = 1'b1;
    tick(1);
    check("mid_rst_aw_valid", 64'(axi.aw_valid), 0);
    check("mid_rst_w_valid",  64'(axi.w_valid),  0);
    check("mid_rst_b_ready",  64'(axi.b_ready),  0);
    check("mid_rst_ack",      64'(ack),          0);
    tick(1);
    expect_wr(0, 32'h400, 32'h44, 1'b0);
    b_en = 1'b1;
    seq.rst = 1'b0;
    wait_ack(2'b01, acyc);
    req[0] = 1'b0;
    tick(2);

`ifdef PWR_WR_ARB_TIMEOUT_EN
    // B never arrives: timeout completes with error, next write is normal
    b_en = 1'b0;
    expect_wr(0, 32'h500, 32'h5, 1'b1);
    addr[0] = 32'h500; data[0] = 32'h5; req[0] = 1'b1; rcyc = cyc;
    wait_ack(2'b01, acyc);
    req[0] = 1'b0;
    check("latency_timeout", 64'(acyc - rcyc), 10);
    b_en = 1'b1;
    tick(2);
    expect_wr(0, 32'h504, 32'h6, 1'b0);
    addr[0] = 32'h504; data[0] = 32'h6; req[0] = 1'b1; rcyc = cyc;
    wait_ack(2'b01, acyc);
    req[0] = 1'b0;
    check("latency_after_timeout", 64'(acyc - rcyc), 3);
    tick(2);
`endif

    tick(5);
    check("scoreboard_drained", 64'(sb.size()), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

`default_nettype wire
